// File: rtl/context_saver_ordered_reduce.sv
`default_nettype none
// ============================================================================
// Module   : context_saver_ordered_reduce
// Purpose  : Parks caller contexts in an in-order FIFO. Each record owes
//            loop_count callee results. The head record consumes exactly that
//            many entries from the callee return FIFO and reduces them.
//            REDUCE_MODE selects the reduction: 0 = void, 1 = last,
//            2 = wrapping sum. The record is then emitted as
//            {caller data, reduced value}.
// Ports    : clk, rst_n (async active-low)
//            caller_*  : record push side with full / almost-full hints
//            callee_*  : first-word-fall-through callee return FIFO
//            output_rdy_in / valid_out / callee_data_out / caller_data_out :
//                        result handshake
//            occupancy_out : FIFO entries plus loaded head
// Option   : `define CONTEXT_SAVER_STATS_EN adds two ports:
//            stat_emitted_out (handshake count) and
//            stat_max_occupancy_out (high-water mark). Both saturate.
// Revision : 1.0 - initial release
// ============================================================================
module context_saver_ordered_reduce #(
  parameter int CALLER_WIDTH       = 64,
  parameter int CALLEE_IN_WIDTH    = 256,
  parameter int CALLEE_OUT_WIDTH   = 24,
  parameter int LOOP_COUNT_WIDTH   = 16,
  parameter int LOG_DEPTH          = 9,
  parameter int ALMOSTFULL_ENTRIES = 0,
  parameter int REDUCE_MODE        = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        caller_wren_in,
  input  logic [LOOP_COUNT_WIDTH-1:0] caller_loop_count_in,
  input  logic [CALLER_WIDTH-1:0]     caller_data_in,
  output logic                        caller_almost_full_out,
  output logic                        caller_full_out,
  input  logic                        callee_empty_in,
  input  logic [CALLEE_IN_WIDTH-1:0]  callee_data_in,
  output logic                        callee_rden_out,
  input  logic                        output_rdy_in,
  output logic                        valid_out,
  output logic [CALLEE_OUT_WIDTH-1:0] callee_data_out,
  output logic [CALLER_WIDTH-1:0]     caller_data_out,
  output logic [LOG_DEPTH:0]          occupancy_out
`ifdef CONTEXT_SAVER_STATS_EN
  ,
  output logic [31:0]                 stat_emitted_out,
  output logic [LOG_DEPTH:0]          stat_max_occupancy_out
`endif
);

  localparam int DEPTH   = 2 ** LOG_DEPTH;
  localparam int REC_W   = LOOP_COUNT_WIDTH + CALLER_WIDTH;
  localparam int AF_THR  = DEPTH - ALMOSTFULL_ENTRIES - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [REC_W-1:0]              mem_q [DEPTH];
  logic [LOG_DEPTH-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LOG_DEPTH:0]            count_q, count_d;
  logic [LOOP_COUNT_WIDTH-1:0]   remaining_q, remaining_d;
  logic [CALLEE_OUT_WIDTH-1:0]   acc_q, acc_d;
  logic [CALLER_WIDTH-1:0]       data_q, data_d;
  logic                          full_q, full_d;
  logic                          afull_q, afull_d;

  logic                          push;
  logic                          load;
  logic                          fifo_empty;
  logic [LOOP_COUNT_WIDTH-1:0]   head_lc;
  logic [CALLER_WIDTH-1:0]       head_data;
  logic [CALLEE_OUT_WIDTH-1:0]   callee_low;
  logic [CALLEE_OUT_WIDTH-1:0]   reduced;
  logic                          unused_callee_bits;

  // Only the low CALLEE_OUT_WIDTH bits of the callee word matter.
  assign unused_callee_bits = ^callee_data_in;
  assign callee_low = callee_data_in[CALLEE_OUT_WIDTH-1:0];

  assign push       = caller_wren_in && !full_q;
  assign fifo_empty = (count_q == '0);
  assign {head_lc, head_data} = mem_q[rd_ptr_q];

  // Value the accumulator takes on a callee pop.
  if (REDUCE_MODE == 1) begin : g_reduce_last
    assign reduced = callee_low;
  end else if (REDUCE_MODE == 2) begin : g_reduce_sum
    assign reduced = acc_q + callee_low;
  end else begin : g_reduce_void
    assign reduced = '0;
  end

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    remaining_d     = remaining_q;
    acc_d           = acc_q;
    data_d          = data_q;
    load            = 1'b0;
    callee_rden_out = 1'b0;
    valid_out       = 1'b0;

    case (state_q)
      IDLE: begin
        load = !fifo_empty;
      end
      COLLECT: begin
        if (!callee_empty_in) begin
          callee_rden_out = 1'b1;
          acc_d           = reduced;
          remaining_d     = remaining_q - LOOP_COUNT_WIDTH'(1);
          if (remaining_q == LOOP_COUNT_WIDTH'(1)) begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        valid_out = 1'b1;
        if (output_rdy_in) begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A head load overrides whatever the state above decided.
    if (load) begin
      data_d = head_data;
      acc_d  = '0;
      if (head_lc == '0) begin
        state_d = EMIT;
      end else begin
        remaining_d = head_lc;
        state_d     = COLLECT;
      end
    end

    count_d = count_q + {{LOG_DEPTH{1'b0}}, push} - {{LOG_DEPTH{1'b0}}, load};
    full_d  = (int'(count_d) == DEPTH);
    // The almost-full threshold is measured on FIFO entries, like full.
    afull_d = (int'(count_d) >= AF_THR);
  end

  // --------------------------------------------------------------------------
  // State and control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      acc_q       <= '0;
      data_q      <= '0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
      data_q      <= data_d;
      count_q     <= count_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + LOG_DEPTH'(1);
      end
      if (load) begin
        rd_ptr_q <= rd_ptr_q + LOG_DEPTH'(1);
      end
    end
  end

  // Storage array carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {caller_loop_count_in, caller_data_in};
    end
  end

  assign caller_full_out        = full_q;
  assign caller_almost_full_out = afull_q;
  assign callee_data_out        = acc_q;
  assign caller_data_out        = data_q;
  assign occupancy_out          = count_q + {{LOG_DEPTH{1'b0}}, (state_q != IDLE)};

`ifdef CONTEXT_SAVER_STATS_EN
  logic [31:0]        stat_emitted_q;
  logic [LOG_DEPTH:0] stat_max_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_emitted_q <= '0;
      stat_max_q     <= '0;
    end else begin
      if (valid_out && output_rdy_in && (stat_emitted_q != '1)) begin
        stat_emitted_q <= stat_emitted_q + 32'd1;
      end
      if (occupancy_out > stat_max_q) begin
        stat_max_q <= occupancy_out;
      end
    end
  end

  assign stat_emitted_out       = stat_emitted_q;
  assign stat_max_occupancy_out = stat_max_q;
`else
  // Statistics counters are not built.
`endif

`ifndef SYNTHESIS
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(caller_wren_in && caller_full_out))
    else $error("context_saver_ordered_reduce: push while full was dropped");
`endif

endmodule
`default_nettype wire

// File: doc/context_saver_ordered_reduce.md
Name: context_saver_ordered_reduce

Overview:
- Successor to the ordered context saver. Parked caller contexts are released strictly in arrival order.
- Each caller record carries a loop count. The block consumes exactly that many callee results for the record, reduces them per a compile-time mode (discard / keep last / wrapping sum), then emits one output pairing caller data with the reduced value.
- Sits between a caller pipeline stage and the return FIFO of a pipelined callee.

Parameters:
- CALLER_WIDTH, 64, width of saved caller context.
- CALLEE_IN_WIDTH, 256, width of callee return FIFO data.
- CALLEE_OUT_WIDTH, 24, width of reduced result; the low bits of callee_data_in are used.
- LOOP_COUNT_WIDTH, 16, width of per-record loop count.
- LOG_DEPTH, 9, log2 of the context FIFO depth (DEPTH = 2**LOG_DEPTH).
- ALMOSTFULL_ENTRIES, 0, caller_almost_full_out asserts when occupancy >= DEPTH - ALMOSTFULL_ENTRIES - 1.
- REDUCE_MODE, 0, selects the reduction: 0 = void (result forced 0), 1 = last result, 2 = sum modulo 2**CALLEE_OUT_WIDTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- caller_wren_in  in  1  push a caller record.
- caller_loop_count_in  in  LOOP_COUNT_WIDTH  number of callee results owed to this record.
- caller_data_in  in  CALLER_WIDTH  saved context.
- caller_almost_full_out  out  1  backpressure hint to the caller.
- caller_full_out  out  1  context FIFO full.
- callee_empty_in  in  1  callee return FIFO empty (first-word-fall-through).
- callee_data_in  in  CALLEE_IN_WIDTH  head of the callee return FIFO.
- callee_rden_out  out  1  pop the callee FIFO.
- output_rdy_in  in  1  downstream ready.
- valid_out  out  1  output valid.
- callee_data_out  out  CALLEE_OUT_WIDTH  reduced result.
- caller_data_out  out  CALLER_WIDTH  context of the emitted record.
- occupancy_out  out  LOG_DEPTH+1  records held (FIFO plus head).

Behaviour:
- Reset (async assert, sync deassert through the caller's reset bridge): state IDLE, FIFO empty, and all outputs 0: valid_out, callee_rden_out, caller_almost_full_out, caller_full_out, callee_data_out, caller_data_out, occupancy_out.
- Context FIFO holds DEPTH records of {loop_count, data}. A push is accepted when caller_wren_in=1 and the FIFO is not full.
- A push while caller_full_out=1 is dropped and fires an assertion error in simulation.
- A record pushed at edge t is eligible to load into the head at edge t+1.
- FSM states: IDLE, COLLECT, EMIT. The head registers are remaining, acc, and data.
  - IDLE: when the FIFO is non-empty, pop it into the head and set acc=0. If loop_count=0 go to EMIT, else set remaining=loop_count and go to COLLECT.
  - COLLECT: callee_rden_out = !callee_empty_in (combinational). On each pop, decrement remaining and update acc per REDUCE_MODE. When the pop makes remaining 0, go to EMIT with the final acc.
  - EMIT: valid_out=1, outputs held stable until output_rdy_in=1. On handshake, load the next head in the same cycle if the FIFO is non-empty (same rules as IDLE), else go to IDLE.
- Throughput: one record per cycle when every loop_count is 0 and output_rdy_in=1 continuously.
- callee_rden_out is never asserted outside COLLECT. Extra callee data is left in the callee FIFO for the next record.
- Sum mode wraps silently. Bits of callee_data_in above CALLEE_OUT_WIDTH are ignored.
- occupancy_out counts FIFO entries plus 1 while a head is loaded.
  - A simultaneous push and head-load leave it unchanged.
  - An EMIT handshake with no reload decrements it.
- caller_full_out = FIFO occupancy == DEPTH. Both full flags are registered and reflect the accepted push/pop of the same edge.
- Reset mid-COLLECT or mid-EMIT discards all records and partial accumulation. Callee entries already popped are lost; no further pops occur until a new record loads.

Optional Feature:
- CONTEXT_SAVER_STATS_EN.
- When defined: adds output ports stat_emitted_out (32 bits, count of EMIT handshakes) and stat_max_occupancy_out (LOG_DEPTH+1 bits, high-water mark of occupancy_out). Both reset to 0 and saturate at their maximum.
- When undefined: the ports and logic do not exist; all other behaviour is identical.

Test Plan:
- Loop-count 0, void mode: push 500 records with data=i and loop_count=0, output_rdy_in=1 -> 500 outputs in order, caller_data_out=i, callee_data_out=0, callee_rden_out never asserted.
- Random loop counts, void mode: 500 records, loop counts random in 0..100, random stalls on all three interfaces -> exactly 500 in-order outputs; the callee FIFO empties exactly; no pop ever occurs in IDLE or EMIT.
- Last mode: record loop_count=3 with callee data 0x11, 0x22, 0x33 -> callee_data_out=0x000033, emitted the cycle after the third pop.
- Sum wrap: CALLEE_OUT_WIDTH=24, loop_count=2 with callee data 0xFFFFFF, 0x000002 -> callee_data_out=0x000001.
- Full/backpressure: LOG_DEPTH=4, output_rdy_in=0 -> caller_full_out asserts after 17 pushes (16 in the FIFO + 1 head) with occupancy_out=17. Push 18 is dropped with an assertion. Releasing ready then drains exactly 17 records.
- Reset mid-COLLECT: loop_count=10, deassert rst_n after 4 pops -> all outputs 0 immediately. After reset release and a new record with loop_count=1, the 5th callee entry is the one consumed.
